// File: rtl/instr_decode_stage_if.sv
// Decode-stage bus: instruction/PC and writeback inputs, decoded fields and
// register reads as outputs. The decode stage connects through the slave modport.
interface instr_decode_stage_if;
  logic [31:0] instruction_i;
  logic [63:0] PC_i;
  logic [4:0]  Rd_prev;
  logic [63:0] RdWriteDataMux_o;
  logic        Reg2Loc;
  logic        RegWrite;
  logic        UncondBr;
  logic [63:0] BrAdder_o;
  logic [63:0] MOVmask_o;
  logic [63:0] Da;
  logic [63:0] Db;
  logic [63:0] ALU_Imm;
  logic [63:0] DT_Address;
  logic [31:0] instruction_o;

  modport master (
    output instruction_i, PC_i, Rd_prev, RdWriteDataMux_o, Reg2Loc, RegWrite, UncondBr,
    input  BrAdder_o, MOVmask_o, Da, Db, ALU_Imm, DT_Address, instruction_o
  );

  modport slave (
    input  instruction_i, PC_i, Rd_prev, RdWriteDataMux_o, Reg2Loc, RegWrite, UncondBr,
    output BrAdder_o, MOVmask_o, Da, Db, ALU_Imm, DT_Address, instruction_o
  );
endinterface

// File: rtl/instr_decode_stage.sv
// ARM64 instruction decode stage: field extraction, immediate extension,
// branch target adder, MOV keep-mask and a 32x64 register file (X31 = zero).

module add64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] sum
);
  assign sum = a + b;
endmodule

module mult_by_four64 (
  input  logic [63:0] value,
  output logic [63:0] product
);
  // Top two bits fall off; target arithmetic wraps modulo 2^64.
  assign product = value << 2;
endmodule

module mov_input_generator (
  input  logic [15:0] value_i,
  input  logic [15:0] mask_i,
  input  logic [1:0]  shamt,
  output logic [63:0] result
);
  localparam int unsigned FIELD_W = 16;

  logic [5:0]  pos;
  logic [63:0] hole;

  assign pos    = {shamt, 4'b0000};
  assign hole   = 64'(16'hFFFF) << pos;
  assign result = ~hole | (64'(value_i & mask_i) << pos);

  logic unused_field_w;
  assign unused_field_w = (FIELD_W == 16);
endmodule

module instr_decode_stage (
  input  logic                 clk,
  input  logic                 reset,
  instr_decode_stage_if.slave  bus
);
  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREGS = 32;

  logic [XLEN-1:0] regs [NREGS];
  logic [31:0]     instr;
  logic [4:0]      rn;
  logic [4:0]      rd;
  logic [4:0]      rm;
  logic [4:0]      rb;
  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] br_off_x4;

  assign instr = bus.instruction_i;
  assign rn    = instr[9:5];
  assign rd    = instr[4:0];
  assign rm    = instr[20:16];
  assign rb    = bus.Reg2Loc ? rm : rd;

  assign bus.instruction_o = instr;
  assign bus.ALU_Imm       = XLEN'(instr[21:10]);
  assign bus.DT_Address    = {{55{instr[20]}}, instr[20:12]};

  // B uses a 26-bit word offset, B.cond/CBZ a 19-bit one.
  assign br_off = bus.UncondBr ? {{38{instr[25]}}, instr[25:0]}
                               : {{45{instr[23]}}, instr[23:5]};

  mult_by_four64 u_x4 (
    .value   (br_off),
    .product (br_off_x4)
  );

  add64 u_br_add (
    .a   (bus.PC_i),
    .b   (br_off_x4),
    .sum (bus.BrAdder_o)
  );

  mov_input_generator u_mov (
    .value_i (16'h0000),
    .mask_i  (16'hFFFF),
    .shamt   (instr[22:21]),
    .result  (bus.MOVmask_o)
  );

  // Register file: reset wins over a same-edge write; X31 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.RegWrite && (bus.Rd_prev != 5'd31)) begin
      regs[bus.Rd_prev] <= bus.RdWriteDataMux_o;
    end
  end

  assign bus.Da = (rn == 5'd31) ? '0 : regs[rn];
  assign bus.Db = (rb == 5'd31) ? '0 : regs[rb];
endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed vectors plus random
// stimulus compared against a behavioural model of decode and the register file.
module tb_instr_decode_stage;
  logic clk;
  logic reset;
  instr_decode_stage_if bus ();

  instr_decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] mreg [32];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_branch(input logic [63:0] pc, input logic [31:0] ins,
                                             input logic unc);
    logic [25:0] f26;
    logic [18:0] f19;
    longint off;
    f26 = ins[25:0];
    f19 = ins[23:5];
    off = unc ? longint'($signed(f26)) : longint'($signed(f19));
    return pc + 64'(off * 4);
  endfunction

  function automatic logic [63:0] exp_mask(input logic [31:0] ins);
    logic [63:0] m;
    int sh;
    sh = int'(ins[22:21]);
    for (int b = 0; b < 64; b++) m[b] = ((b / 16) == sh) ? 1'b0 : 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] exp_dt(input logic [31:0] ins);
    logic [8:0] f;
    f = ins[20:12];
    return 64'(longint'($signed(f)));
  endfunction

  function automatic logic [31:0] rinstr(input logic [4:0] rn, input logic [4:0] rd,
                                         input logic [4:0] rm);
    return {11'b0, rm, 6'b0, rn, rd};
  endfunction

  // One clock edge with the model mirroring the architectural write rules.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) mreg[i] = 64'd0;
    end else if (bus.RegWrite && bus.Rd_prev != 5'd31) begin
      mreg[bus.Rd_prev] = bus.RdWriteDataMux_o;
    end
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [63:0] d);
    bus.RegWrite = 1'b1;
    bus.Rd_prev = a;
    bus.RdWriteDataMux_o = d;
    step();
    bus.RegWrite = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [4:0] rn, input logic [4:0] rd,
                            input logic [4:0] rm, input logic sel);
    bus.instruction_i = rinstr(rn, rd, rm);
    bus.Reg2Loc = sel;
    #1;
    check({tag, "_da"}, bus.Da, (rn == 5'd31) ? 64'd0 : mreg[rn]);
    check({tag, "_db"}, bus.Db, sel ? ((rm == 5'd31) ? 64'd0 : mreg[rm])
                                    : ((rd == 5'd31) ? 64'd0 : mreg[rd]));
  endtask

  task automatic br_check(input string tag, input logic [31:0] ins, input logic unc,
                          input logic [63:0] pc, input logic [63:0] exp);
    bus.instruction_i = ins;
    bus.UncondBr = unc;
    bus.PC_i = pc;
    #1;
    check(tag, bus.BrAdder_o, exp);
  endtask

  initial begin
    logic [31:0] ins;
    logic [63:0] pc;
    logic unc;
    logic [4:0] a;

    reset = 1'b1;
    bus.instruction_i = '0;
    bus.PC_i = '0;
    bus.Rd_prev = '0;
    bus.RdWriteDataMux_o = '0;
    bus.Reg2Loc = 1'b0;
    bus.RegWrite = 1'b0;
    bus.UncondBr = 1'b0;
    @(negedge clk);
    step();
    reset = 1'b0;

    for (int r = 0; r < 32; r++) read_check("reset_state", 5'(r), 5'(r), 5'(r), 1'b1);

    for (int i = 0; i < 20; i++) begin
      ins = $urandom;
      bus.instruction_i = ins;
      #1;
      check("passthru", 64'(bus.instruction_o), 64'(ins));
    end

    br_check("b_plus7",      32'h14000007, 1'b1, 64'd0, 64'd28);
    br_check("b_minus7",     32'h17FFFFF9, 1'b1, 64'd0, -64'sd28);
    br_check("blt_plus8",    32'h5400010B, 1'b0, 64'd0, 64'd32);
    br_check("cbz_plus20",   32'hB400029F, 1'b0, 64'd0, 64'd80);
    br_check("cbz_minus1",   32'hB4FFFFFF, 1'b0, 64'd0, -64'sd4);
    br_check("mux_unc_cbz",  32'hB400029F, 1'b1, 64'd0, 64'd2684);
    br_check("mux_cond_b",   32'h17FFFFF9, 1'b0, 64'd0, -64'sd4);
    br_check("b_wrap",       32'h17FFFFFF, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC);
    for (int i = 0; i < 20; i++) begin
      ins = $urandom;
      pc = {$urandom, $urandom};
      unc = 1'($urandom);
      br_check("br_rand", ins, unc, pc, exp_branch(pc, ins, unc));
    end

    bus.instruction_i = 32'hF2DBD5A1;
    #1;
    check("movk_lsl32", bus.MOVmask_o, 64'hFFFF_0000_FFFF_FFFF);
    bus.instruction_i = 32'hD2F95FC0;
    #1;
    check("movz_lsl48", bus.MOVmask_o, 64'h0000_FFFF_FFFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      ins = $urandom;
      bus.instruction_i = ins;
      #1;
      check("mov_rand", bus.MOVmask_o, exp_mask(ins));
    end

    for (int i = 0; i < 20; i++) begin
      ins = $urandom;
      bus.instruction_i = ins;
      #1;
      check("alu_imm", bus.ALU_Imm, 64'(int'(ins[21:10])));
      check("dt_addr", bus.DT_Address, exp_dt(ins));
    end
    bus.instruction_i = 32'h0010_0000;
    #1;
    check("dt_neg_edge", bus.DT_Address, 64'hFFFF_FFFF_FFFF_FF00);
    bus.instruction_i = 32'h003F_FC00;
    #1;
    check("alu_imm_max", bus.ALU_Imm, 64'd4095);

    write_reg(5'd0, 64'd1738);
    write_reg(5'd1, 64'd42069);
    write_reg(5'd2, -64'sd15);
    bus.RegWrite = 1'b0;
    bus.Rd_prev = 5'd2;
    bus.RdWriteDataMux_o = 64'd999;
    step();
    bus.instruction_i = rinstr(5'd0, 5'd2, 5'd1);
    bus.Reg2Loc = 1'b0;
    #1;
    check("rf_da_x0", bus.Da, 64'd1738);
    check("rf_db_x2", bus.Db, -64'sd15);
    bus.Reg2Loc = 1'b1;
    #1;
    check("rf_db_x1", bus.Db, 64'd42069);

    write_reg(5'd31, 64'h1234_5678);
    read_check("x31_write", 5'd31, 5'd31, 5'd31, 1'b0);
    bus.instruction_i = rinstr(5'd31, 5'd31, 5'd31);
    #1;
    check("x31_zero", bus.Da, 64'd0);

    bus.RegWrite = 1'b1;
    bus.Rd_prev = 5'd3;
    bus.RdWriteDataMux_o = 64'hABCD;
    bus.instruction_i = rinstr(5'd3, 5'd3, 5'd3);
    #1;
    check("no_write_through", bus.Da, mreg[3]);
    bus.RegWrite = 1'b0;

    for (int i = 0; i < 40; i++) begin
      a = 5'($urandom);
      bus.RegWrite = 1'($urandom);
      bus.Rd_prev = a;
      bus.RdWriteDataMux_o = {$urandom, $urandom};
      step();
      bus.RegWrite = 1'b0;
      read_check("rf_rand", a, 5'($urandom), a, 1'($urandom));
    end

    write_reg(5'd5, 64'd123);
    read_check("x5_before_rst", 5'd5, 5'd5, 5'd5, 1'b0);
    reset = 1'b1;
    bus.RegWrite = 1'b1;
    bus.Rd_prev = 5'd5;
    bus.RdWriteDataMux_o = 64'd77;
    step();
    reset = 1'b0;
    bus.RegWrite = 1'b0;
    bus.instruction_i = rinstr(5'd5, 5'd5, 5'd5);
    #1;
    check("rst_beats_write", bus.Da, 64'd0);
    for (int r = 0; r < 31; r++) begin
      bus.instruction_i = rinstr(5'(r), 5'd0, 5'd0);
      #1;
      check("post_reset", bus.Da, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
